data_memory_lsu: RTL and testbench

- Initiator side of the data memory. Accepts RV32 load/store requests from the core pipeline and drives the word-addressed, byte-enabled, one-cycle-read-latency data memory port.
- Produces lane-aligned write data and byte enables, and sign/zero-extends load results.
- Splits word-crossing (misaligned) accesses into two sequential word accesses.

---
 rtl/riscv_mem_pkg.sv | 39 +++
 rtl/data_memory_lsu_if.sv | 22 ++
 rtl/data_memory_lsu_lane_align.sv | 32 +++
 rtl/data_memory_lsu.sv | 135 +++++++++++++
 tb/tb_data_memory_lsu.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32 data-memory load/store unit:
// funct3 encodings, LSU state encoding and access helpers.
package riscv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [2:0] {
      IDLE,
      ACC0,
      ACC1,
      WAIT,
      DONE
   } lsu_state_t;

   // Byte-lane mask of the access size, before shifting to the byte offset.
   function automatic logic [3:0] size_mask(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         2'b10:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic is_legal(input logic write, input logic [2:0] funct3);
      if (write)
         return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
      return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
             (funct3 == F3_LBU) || (funct3 == F3_LHU);
   endfunction

endpackage

// File: rtl/data_memory_lsu_if.sv
// Core-side request/response bus of the data-memory LSU.
interface data_memory_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_error;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_error, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_error, resp_rdata
   );
endinterface

// File: rtl/data_memory_lsu_lane_align.sv
// Combinational lane steering: store mask/data spread over two words,
// and extraction plus sign/zero extension of load data from two words.
module lsu_lane_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [7:0]  lane_mask,
   output logic [63:0] lane_data,
   output logic [31:0] load_result
);

   logic [31:0] shifted;

   assign lane_mask = {4'b0000, size_mask(funct3)} << offset;
   assign lane_data = {32'h0, wdata} << {offset, 3'b000};
   assign shifted   = 32'({hi, lo} >> {offset, 3'b000});

   // funct3[2] selects zero extension for LBU/LHU.
   always_comb begin
      load_result = shifted;
      case (funct3[1:0])
         2'b00:   load_result = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
         2'b01:   load_result = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
         default: load_result = shifted;
      endcase
   end

endmodule

// File: rtl/data_memory_lsu.sv
// RV32 load/store initiator for a word-addressed, byte-enabled memory with
// one-cycle read latency; word-crossing accesses are split into two accesses.
module data_memory_lsu
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   data_memory_lsu_if.slave      bus,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [3:0]            mem_byteena,
   output logic [31:0]           mem_data,
   output logic                  mem_wren,
   input  logic [31:0]           mem_q
);

   lsu_state_t state, next_state;

   logic                  wr_q;
   logic [2:0]            f3_q;
   logic [1:0]            off_q;
   logic [ADDR_WIDTH-1:0] word_q;
   logic [31:0]           wdata_q;
   logic [31:0]           lo_q;
   logic                  resp_valid_q;
   logic                  resp_error_q;
   logic [31:0]           resp_rdata_q;

   logic                  idle;
   logic [2:0]            sel_f3;
   logic [1:0]            sel_off;
   logic [31:0]           sel_wdata;
   logic [7:0]            lane_mask;
   logic [63:0]           lane_data;
   logic [31:0]           ext_hi;
   logic [31:0]           ext_lo;
   logic [31:0]           load_result;
   logic                  split;
   logic                  unused_addr;

   assign idle          = (state == IDLE);
   assign bus.req_ready = idle;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_error = resp_error_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign unused_addr   = ^bus.req_addr[31:ADDR_WIDTH+2];

   // In IDLE the aligner sees the live request so the first word can be
   // registered on the accept edge; afterwards it sees the latched request.
   assign sel_f3    = idle ? bus.req_funct3     : f3_q;
   assign sel_off   = idle ? bus.req_addr[1:0]  : off_q;
   assign sel_wdata = idle ? bus.req_wdata      : wdata_q;
   assign split     = |lane_mask[7:4];

   // Only consulted in WAIT, where mem_q carries the last word read.
   assign ext_hi = split ? mem_q : 32'h0;
   assign ext_lo = split ? lo_q  : mem_q;

   lsu_lane_align u_align (
      .funct3      (sel_f3),
      .offset      (sel_off),
      .wdata       (sel_wdata),
      .hi          (ext_hi),
      .lo          (ext_lo),
      .lane_mask   (lane_mask),
      .lane_data   (lane_data),
      .load_result (load_result)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (bus.req_valid)
                  next_state = is_legal(bus.req_write, bus.req_funct3) ? ACC0 : DONE;
         ACC0: next_state = split ? ACC1 : (wr_q ? DONE : WAIT);
         ACC1: next_state = wr_q ? DONE : WAIT;
         WAIT: next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         wr_q         <= 1'b0;
         f3_q         <= 3'b000;
         off_q        <= 2'b00;
         word_q       <= '0;
         wdata_q      <= 32'h0;
         lo_q         <= 32'h0;
         mem_address  <= '0;
         mem_byteena  <= 4'b0000;
         mem_data     <= 32'h0;
         mem_wren     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state <= next_state;
         if (idle && bus.req_valid) begin
            wr_q    <= bus.req_write;
            f3_q    <= bus.req_funct3;
            off_q   <= bus.req_addr[1:0];
            word_q  <= bus.req_addr[ADDR_WIDTH+1:2];
            wdata_q <= bus.req_wdata;
         end
         if (state == ACC1)
            lo_q <= mem_q;

         if (idle && next_state == ACC0) begin
            mem_address <= bus.req_addr[ADDR_WIDTH+1:2];
            mem_byteena <= lane_mask[3:0];
            mem_data    <= lane_data[31:0];
            mem_wren    <= bus.req_write;
         end else if (next_state == ACC1) begin
            mem_address <= word_q + ADDR_WIDTH'(1);
            mem_byteena <= lane_mask[7:4];
            mem_data    <= lane_data[63:32];
            mem_wren    <= wr_q;
         end else begin
            mem_byteena <= 4'b0000;
            mem_wren    <= 1'b0;
         end

         resp_valid_q <= (next_state == DONE);
         if (next_state == DONE) begin
            resp_error_q <= idle;
            resp_rdata_q <= (state == WAIT) ? load_result : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed self-checking bench for data_memory_lsu with a behavioural
// byte-enabled memory that has one cycle of read latency.
module tb_data_memory_lsu;

   typedef struct packed {
      logic        wren;
      logic [14:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } acc_t;

   logic        clock;
   logic        reset;
   logic [14:0] mem_address;
   logic [3:0]  mem_byteena;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic [31:0] mem_q;
   logic [31:0] mem [0:32767];
   acc_t        acc_log[$];
   int          checks;
   int          failures;

   data_memory_lsu_if bus ();

   data_memory_lsu #(.ADDR_WIDTH(15)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .mem_address (mem_address),
      .mem_byteena (mem_byteena),
      .mem_data    (mem_data),
      .mem_wren    (mem_wren),
      .mem_q       (mem_q)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Memory model plus a log of every access the DUT presents.
   always @(posedge clock) begin
      if (mem_byteena != 4'b0000)
         acc_log.push_back('{mem_wren, mem_address, mem_byteena, mem_data});
      if (mem_wren) begin
         if (mem_byteena[0]) mem[mem_address][7:0]   <= mem_data[7:0];
         if (mem_byteena[1]) mem[mem_address][15:8]  <= mem_data[15:8];
         if (mem_byteena[2]) mem[mem_address][23:16] <= mem_data[23:16];
         if (mem_byteena[3]) mem[mem_address][31:24] <= mem_data[31:24];
      end
      mem_q <= mem[mem_address];
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One request; lat counts edges from the accept edge until resp_valid.
   task automatic applyStimulus(input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output int lat, output logic [31:0] rd,
                                output logic er);
      acc_log.delete();
      @(negedge clock);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      if (!bus.resp_valid)
         checkOutput("resp_timeout", 64'(bus.resp_valid), 64'd1);
      rd = bus.resp_rdata;
      er = bus.resp_error;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      checks   = 0;
      failures = 0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      reset = 1'b1;
      #12;
      checkOutput("rst_ready", 64'(bus.req_ready), 64'd1);
      checkOutput("rst_mem", {mem_wren, mem_byteena, mem_address, mem_data}, 64'd0);
      checkOutput("rst_resp", {bus.resp_valid, bus.resp_error, bus.resp_rdata}, 64'd0);
      @(negedge clock);
      reset = 1'b0;

      applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er);
      checkOutput("sw_lat", 64'(lat), 64'd2);
      checkOutput("sw_rdata", {er, rd}, 64'd0);
      checkOutput("sw_nacc", 64'(acc_log.size()), 64'd1);
      checkOutput("sw_acc0", 64'(acc_log[0]), 64'({1'b1, 15'd4, 4'b1111, 32'hDEADBEEF}));
      checkOutput("sw_after", {bus.resp_valid, bus.req_ready}, 64'b01);

      applyStimulus(1'b1, 3'b000, 32'h13, 32'h000000A5, lat, rd, er);
      checkOutput("sb_lat", 64'(lat), 64'd2);
      checkOutput("sb_nacc", 64'(acc_log.size()), 64'd1);
      checkOutput("sb_acc0", 64'({acc_log[0].wren, acc_log[0].addr, acc_log[0].be,
                                  acc_log[0].data[31:24]}),
                  64'({1'b1, 15'd4, 4'b1000, 8'hA5}));
      checkOutput("sb_mem4", 64'(mem[4]), 64'hA5ADBEEF);

      applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, lat, rd, er);
      checkOutput("lbu_lat", 64'(lat), 64'd3);
      checkOutput("lbu_rdata", {er, rd}, 64'h0_000000A5);
      checkOutput("lbu_acc0", 64'({acc_log[0].wren, acc_log[0].addr, acc_log[0].be}),
                  64'({1'b0, 15'd4, 4'b1000}));
      applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, er);
      checkOutput("lb_rdata", 64'(rd), 64'hFFFFFFA5);
      applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, er);
      checkOutput("lh_rdata", 64'(rd), 64'hFFFFA5AD);
      applyStimulus(1'b0, 3'b101, 32'h10, 32'h0, lat, rd, er);
      checkOutput("lhu_rdata", 64'(rd), 64'h0000BEEF);

      applyStimulus(1'b1, 3'b010, 32'h22, 32'h11223344, lat, rd, er);
      checkOutput("msw_lat", 64'(lat), 64'd3);
      checkOutput("msw_nacc", 64'(acc_log.size()), 64'd2);
      checkOutput("msw_acc0", 64'(acc_log[0]), 64'({1'b1, 15'd8, 4'b1100, 32'h33440000}));
      checkOutput("msw_acc1", 64'(acc_log[1]), 64'({1'b1, 15'd9, 4'b0011, 32'h00001122}));
      applyStimulus(1'b0, 3'b010, 32'h22, 32'h0, lat, rd, er);
      checkOutput("mlw_lat", 64'(lat), 64'd4);
      checkOutput("mlw_rdata", {er, rd}, 64'h0_11223344);

      applyStimulus(1'b1, 3'b010, 32'h0001FFFC, 32'h81000000, lat, rd, er);
      applyStimulus(1'b1, 3'b010, 32'h00000000, 32'h000000C2, lat, rd, er);
      applyStimulus(1'b0, 3'b001, 32'h0001FFFF, 32'h0, lat, rd, er);
      checkOutput("wrap_lat", 64'(lat), 64'd4);
      checkOutput("wrap_rdata", 64'(rd), 64'hFFFFC281);
      checkOutput("wrap_acc0", 64'(acc_log[0]), 64'({1'b0, 15'h7FFF, 4'b1000, 32'h0}));
      checkOutput("wrap_acc1", 64'(acc_log[1]), 64'({1'b0, 15'h0000, 4'b0001, 32'h0}));
      applyStimulus(1'b0, 3'b101, 32'h0001FFFF, 32'h0, lat, rd, er);
      checkOutput("wrap_lhu", 64'(rd), 64'h0000C281);

      applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er);
      checkOutput("eld_lat", 64'(lat), 64'd1);
      checkOutput("eld_resp", {er, rd}, 64'h1_00000000);
      checkOutput("eld_nacc", 64'(acc_log.size()), 64'd0);
      checkOutput("eld_hold", {bus.resp_valid, bus.resp_error}, 64'b01);
      applyStimulus(1'b1, 3'b100, 32'h10, 32'h12345678, lat, rd, er);
      checkOutput("est_lat", 64'(lat), 64'd1);
      checkOutput("est_resp", {er, rd}, 64'h1_00000000);
      checkOutput("est_nacc", 64'(acc_log.size()), 64'd0);
      checkOutput("est_mem4", 64'(mem[4]), 64'hA5ADBEEF);

      applyStimulus(1'b1, 3'b010, 32'h30, 32'h00000000, lat, rd, er);
      checkOutput("clr_error", {er, rd}, 64'd0);
      applyStimulus(1'b1, 3'b010, 32'h34, 32'h55555555, lat, rd, er);

      // Split SH interrupted by reset while the second word is presented.
      @(negedge clock);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'b001;
      bus.req_addr   = 32'h33;
      bus.req_wdata  = 32'h00007788;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("rsplit_acc1", {mem_wren, mem_address, mem_byteena, mem_data},
                  64'({1'b1, 15'd13, 4'b0001, 32'h00000077}));
      reset = 1'b1;
      #1;
      checkOutput("rsplit_mem", {mem_wren, mem_byteena, mem_address, mem_data}, 64'd0);
      checkOutput("rsplit_resp", {bus.resp_valid, bus.resp_error, bus.resp_rdata}, 64'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("rsplit_ready", 64'(bus.req_ready), 64'd1);
      checkOutput("rsplit_w12", 64'(mem[12]), 64'h88000000);
      checkOutput("rsplit_w13", 64'(mem[13]), 64'h55555555);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
